// File: rtl/m68k_bus_ctrl.sv
// 68000 bus controller: region decode, per-region wait states, DTACK/BERR
// generation with a timeout for unmapped accesses and a saturating error count.
module m68k_bus_ctrl #(
  parameter int                      N_REGIONS   = 4,
  parameter logic [23*N_REGIONS-1:0] REGION_BASE = {23'h18000, 23'h10000, 23'h08000, 23'h00000},
  parameter logic [23*N_REGIONS-1:0] REGION_MASK = {4{23'h7F8000}},
  parameter logic [4*N_REGIONS-1:0]  REGION_WAIT = {4'd0, 4'd0, 4'd1, 4'd0},
  parameter int                      TIMEOUT     = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      as_n,
  input  logic                      rw,
  input  logic                      uds_n,
  input  logic                      lds_n,
  input  logic [22:0]               addr,
  input  logic [16*N_REGIONS-1:0]   region_dout,
  output logic [15:0]               cpu_din,
  output logic [N_REGIONS-1:0]      sel,
  output logic [N_REGIONS-1:0]      rd_stb,
  output logic [N_REGIONS-1:0]      wr_stb,
  output logic [1:0]                be,
  output logic                      dtack_n,
  output logic                      berr_n,
  output logic                      busy,
  output logic [7:0]                err_count
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_TOUT, S_ERR, S_RECOVER} state_t;

  state_t                r_state, w_nx_state;
  logic [3:0]            r_wcnt, w_nx_wcnt;
  logic [7:0]            r_tcnt, w_nx_tcnt;
  logic                  r_rw, w_nx_rw;
  logic [N_REGIONS-1:0]  r_sel, w_nx_sel;
  logic [N_REGIONS-1:0]  r_rd_stb, w_nx_rd_stb;
  logic [N_REGIONS-1:0]  r_wr_stb, w_nx_wr_stb;
  logic [1:0]            r_be, w_nx_be;
  logic                  r_dtack_n, w_nx_dtack_n;
  logic                  r_berr_n, w_nx_berr_n;
  logic [15:0]           r_din, w_nx_din;
  logic [7:0]            r_err, w_nx_err;

  logic [N_REGIONS-1:0]  w_hit, w_first;
  logic [3:0]            w_wait;
  logic [15:0]           w_rdata;

  // Lowest-index hit wins: isolate the lowest set bit so overlaps stay one-hot.
  always_comb begin
    for (int i = 0; i < N_REGIONS; i++)
      w_hit[i] = (addr & REGION_MASK[23*i +: 23]) == (REGION_BASE[23*i +: 23] & REGION_MASK[23*i +: 23]);
  end
  assign w_first = w_hit & (-w_hit);

  always_comb begin
    w_wait  = '0;
    w_rdata = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (w_first[i]) w_wait  = w_wait  | REGION_WAIT[4*i +: 4];
      if (r_sel[i])   w_rdata = w_rdata | region_dout[16*i +: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_wcnt    <= '0;
      r_tcnt    <= '0;
      r_rw      <= 1'b1;
      r_sel     <= '0;
      r_rd_stb  <= '0;
      r_wr_stb  <= '0;
      r_be      <= '0;
      r_dtack_n <= 1'b1;
      r_berr_n  <= 1'b1;
      r_din     <= 16'hFFFF;
      r_err     <= '0;
    end else begin
      r_state   <= w_nx_state;
      r_wcnt    <= w_nx_wcnt;
      r_tcnt    <= w_nx_tcnt;
      r_rw      <= w_nx_rw;
      r_sel     <= w_nx_sel;
      r_rd_stb  <= w_nx_rd_stb;
      r_wr_stb  <= w_nx_wr_stb;
      r_be      <= w_nx_be;
      r_dtack_n <= w_nx_dtack_n;
      r_berr_n  <= w_nx_berr_n;
      r_din     <= w_nx_din;
      r_err     <= w_nx_err;
    end
  end

  always_comb begin
    w_nx_state   = r_state;
    w_nx_wcnt    = r_wcnt;
    w_nx_tcnt    = r_tcnt;
    w_nx_rw      = r_rw;
    w_nx_sel     = r_sel;
    w_nx_rd_stb  = '0;
    w_nx_wr_stb  = '0;
    w_nx_be      = r_be;
    w_nx_dtack_n = r_dtack_n;
    w_nx_berr_n  = r_berr_n;
    w_nx_din     = r_din;
    w_nx_err     = r_err;
    case (r_state)
      S_IDLE: if (!as_n) begin
        w_nx_sel = w_first;
        w_nx_be  = {~uds_n, ~lds_n};
        w_nx_rw  = rw;
        if (|w_hit) begin
          w_nx_rd_stb = rw ? w_first : '0;
          w_nx_wcnt   = w_wait;
          w_nx_state  = S_WAIT;
        end else begin
          w_nx_tcnt  = 8'(TIMEOUT - 1);
          w_nx_state = S_TOUT;
        end
      end
      S_WAIT: begin
        if (as_n)              w_nx_state = S_RECOVER;
        else if (r_wcnt == '0) begin
          w_nx_dtack_n = 1'b0;
          w_nx_din     = w_rdata;
          w_nx_wr_stb  = r_rw ? '0 : r_sel;
          w_nx_state   = S_ACK;
        end else               w_nx_wcnt = r_wcnt - 4'd1;
      end
      S_ACK:  if (as_n) w_nx_state = S_RECOVER;
      S_TOUT: begin
        if (as_n)              w_nx_state = S_RECOVER;
        else if (r_tcnt == '0) begin
          w_nx_berr_n = 1'b0;
          w_nx_err    = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
          w_nx_state  = S_ERR;
        end else               w_nx_tcnt = r_tcnt - 8'd1;
      end
      S_ERR:     if (as_n) w_nx_state = S_RECOVER;
      S_RECOVER: w_nx_state = S_IDLE;
      default:   w_nx_state = S_IDLE;
    endcase
    // Every path into RECOVER drops the bus back to its idle levels.
    if (w_nx_state == S_RECOVER) begin
      w_nx_sel     = '0;
      w_nx_be      = '0;
      w_nx_dtack_n = 1'b1;
      w_nx_berr_n  = 1'b1;
      w_nx_din     = 16'hFFFF;
    end
  end

  assign cpu_din   = r_din;
  assign sel       = r_sel;
  assign rd_stb    = r_rd_stb;
  assign wr_stb    = r_wr_stb;
  assign be        = r_be;
  assign dtack_n   = r_dtack_n;
  assign berr_n    = r_berr_n;
  assign busy      = (r_state != S_IDLE);
  assign err_count = r_err;

endmodule
